// File: rtl/alu_seq_if.sv
// alu_seq_if: operand/opcode request channel and result channel of alu_seq.
// master drives operations and consumes results; slave is the ALU.
interface alu_seq_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       opcode;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [3:0]       status;
    logic             err;

    modport master (
        output in_valid, a, b, opcode, cin, out_ready,
        input  in_ready, out_valid, result, status, err
    );

    modport slave (
        input  in_valid, a, b, opcode, cin, out_ready,
        output in_ready, out_valid, result, status, err
    );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: registered valid/ready ALU with flags and illegal-opcode error.
// Define ALU_MUL_EN to build the iterative shift-add multiplier for opcode 1001.
//
// state | meaning
// IDLE  | accepting ops; single-cycle ops complete from here
// MUL   | shift-add iterations in progress (ALU_MUL_EN only)
module alu_seq #(
    parameter int WIDTH = 32
) (
    input logic      clk,
    input logic      rst_n,
    alu_seq_if.slave bus
);
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0010;
    localparam logic [3:0] OP_AND = 4'b0011;
    localparam logic [3:0] OP_OR  = 4'b0100;
    localparam logic [3:0] OP_NOR = 4'b0101;
    localparam logic [3:0] OP_SHR = 4'b0110;
    localparam logic [3:0] OP_SHL = 4'b0111;
    localparam logic [3:0] OP_SUB = 4'b1000;
    localparam logic [3:0] OP_MUL = 4'b1001;
    localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);

    logic             in_ready_i, accept, out_load, is_mul, idle;
    logic             out_valid_q, err_q, err_d, op_err, op_c, op_v;
    logic [WIDTH-1:0] result_q, res_d, op_res;
    logic [3:0]       status_q, st_d, op_st;
    logic [WIDTH:0]   sum;

    always_comb begin
        op_res = '0;
        op_err = 1'b0;
        op_c   = 1'b0;
        op_v   = 1'b0;
        sum    = '0;
        case (bus.opcode)
            OP_ADD: begin
                sum    = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, bus.cin};
                op_res = sum[WIDTH-1:0];
                op_c   = sum[WIDTH];
                op_v   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
                sum    = {1'b0, bus.a} + {1'b0, ~bus.b} + {{WIDTH{1'b0}}, 1'b1};
                op_res = sum[WIDTH-1:0];
                op_c   = sum[WIDTH];
                op_v   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_XOR: op_res = bus.a ^ bus.b;
            OP_AND: op_res = bus.a & bus.b;
            OP_OR:  op_res = bus.a | bus.b;
            OP_NOR: op_res = ~(bus.a | bus.b);
            OP_SHR: op_res = (bus.b >= WIDTH_V) ? '0 : (bus.a >> bus.b);
            OP_SHL: op_res = (bus.b >= WIDTH_V) ? '0 : (bus.a << bus.b);
            default: op_err = 1'b1;
        endcase
        op_st = op_err ? 4'b0000 : {op_res[WIDTH-1], op_res == '0, op_c, op_v};
    end

`ifdef ALU_MUL_EN
    localparam int CNT_W = $clog2(WIDTH) + 1;
    typedef enum logic {ST_IDLE, ST_MUL} state_t;

    state_t             state, state_nx;
    logic [2*WIDTH-1:0] mcand, acc, acc_nx;
    logic [WIDTH-1:0]   mplier;
    logic [CNT_W-1:0]   cnt;
    logic               mul_done;

    assign is_mul   = (bus.opcode == OP_MUL);
    assign idle     = (state == ST_IDLE);
    assign acc_nx   = acc + (mplier[0] ? mcand : '0);
    assign mul_done = (state == ST_MUL) && (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (accept && is_mul) state_nx = ST_MUL;
            ST_MUL:  if (mul_done) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else if (accept && is_mul) begin
            mcand  <= {{WIDTH{1'b0}}, bus.a};
            mplier <= bus.b;
            acc    <= '0;
            cnt    <= '0;
        end else if (state == ST_MUL) begin
            acc    <= acc_nx;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
        end
    end
`else
    assign is_mul = 1'b0;
    assign idle   = 1'b1;
`endif

    always_comb begin
        in_ready_i = idle && (!out_valid_q || bus.out_ready);
        accept     = bus.in_valid && in_ready_i;
        out_load   = accept && !is_mul;
        res_d      = op_res;
        st_d       = op_st;
        err_d      = op_err;
`ifdef ALU_MUL_EN
        // Final iteration folds straight into the output register.
        if (mul_done) begin
            out_load = 1'b1;
            res_d    = acc_nx[WIDTH-1:0];
            st_d     = {acc_nx[WIDTH-1], acc_nx[WIDTH-1:0] == '0, |acc_nx[2*WIDTH-1:WIDTH], 1'b0};
            err_d    = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            status_q    <= 4'b0000;
            err_q       <= 1'b0;
        end else if (out_load) begin
            out_valid_q <= 1'b1;
            result_q    <= res_d;
            status_q    <= st_d;
            err_q       <= err_d;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready_i;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.status    = status_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors with hand-computed results for alu_seq (WIDTH=32).
// MUL vectors are exercised when ALU_MUL_EN is defined; otherwise 1001 must be illegal.
module tb_alu_seq;
    localparam int WIDTH = 32;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0010;
    localparam logic [3:0] OP_AND = 4'b0011;
    localparam logic [3:0] OP_OR  = 4'b0100;
    localparam logic [3:0] OP_NOR = 4'b0101;
    localparam logic [3:0] OP_SHR = 4'b0110;
    localparam logic [3:0] OP_SHL = 4'b0111;
    localparam logic [3:0] OP_SUB = 4'b1000;
    localparam logic [3:0] OP_MUL = 4'b1001;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   lat;
    logic flag;

    alu_seq_if #(.WIDTH(WIDTH)) bus ();
    alu_seq #(.WIDTH(WIDTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv, input logic c);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.opcode   = op;
        bus.a        = av;
        bus.b        = bv;
        bus.cin      = c;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [31:0] r, input logic [3:0] s, input logic e);
        chk({tag, " out_valid"}, bus.out_valid, 1);
        chk({tag, " result"}, bus.result, r);
        chk({tag, " status"}, bus.status, s);
        chk({tag, " err"}, bus.err, e);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.opcode    = 4'b0000;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset out_valid", bus.out_valid, 0);
        chk("reset result", bus.result, 0);
        chk("reset status", bus.status, 0);
        chk("reset err", bus.err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post-reset in_ready", bus.in_ready, 1);

        // Arithmetic, flags and one-cycle latency, back-to-back
        issue(OP_ADD, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        expect_out("add carry", 32'h0000_0000, 4'b0110, 1'b0);
        issue(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0000, 1'b1);
        expect_out("add ovf", 32'h8000_0000, 4'b1001, 1'b0);
        issue(OP_SUB, 32'h8000_0000, 32'h0000_0001, 1'b0);
        expect_out("sub ovf", 32'h7FFF_FFFF, 4'b0011, 1'b0);
        issue(OP_SUB, 32'h0000_0005, 32'h0000_0005, 1'b1);
        expect_out("sub zero", 32'h0000_0000, 4'b0110, 1'b0);
        issue(OP_SUB, 32'h0000_0000, 32'h0000_0001, 1'b1);
        expect_out("sub borrow", 32'hFFFF_FFFF, 4'b1000, 1'b0);

        // Bitwise
        issue(OP_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1);
        expect_out("xor", 32'h0FF0_0FF0, 4'b0000, 1'b0);
        issue(OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0);
        expect_out("and", 32'hF000_F000, 4'b1000, 1'b0);
        issue(OP_OR, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0);
        expect_out("or", 32'hFFF0_FFF0, 4'b1000, 1'b0);
        issue(OP_NOR, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0);
        expect_out("nor", 32'h000F_000F, 4'b0000, 1'b0);

        // Shifts, including amount boundaries and large b
        issue(OP_SHL, 32'h0000_0001, 32'h0000_0020, 1'b0);
        expect_out("shl 32", 32'h0000_0000, 4'b0100, 1'b0);
        issue(OP_SHR, 32'h8000_0000, 32'h0000_001F, 1'b0);
        expect_out("shr 31", 32'h0000_0001, 4'b0000, 1'b0);
        issue(OP_SHL, 32'h0000_0001, 32'h0000_001F, 1'b1);
        expect_out("shl 31", 32'h8000_0000, 4'b1000, 1'b0);
        issue(OP_SHR, 32'hFFFF_FFFF, 32'h0000_0020, 1'b0);
        expect_out("shr 32", 32'h0000_0000, 4'b0100, 1'b0);
        issue(OP_SHL, 32'h0000_0003, 32'h8000_0001, 1'b0);
        expect_out("shl big b", 32'h0000_0000, 4'b0100, 1'b0);

        // Illegal opcodes
        issue(4'b1111, 32'h1234_5678, 32'h0000_0001, 1'b1);
        expect_out("illegal 1111", 32'h0000_0000, 4'b0000, 1'b1);
        issue(4'b0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        expect_out("illegal 0000", 32'h0000_0000, 4'b0000, 1'b1);
        issue(OP_ADD, 32'h0000_0001, 32'h0000_0002, 1'b1);
        expect_out("add after err", 32'h0000_0004, 4'b0000, 1'b0);

        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("drain out_valid", bus.out_valid, 0);

        // Backpressure: hold the first result, then drain the rest in order
        issue(OP_ADD, 32'h0000_0001, 32'h0000_0002, 1'b0);
        expect_out("bp first", 32'h0000_0003, 4'b0000, 1'b0);
        @(negedge clk);
        bus.a         = 32'h0000_0010;
        bus.b         = 32'h0000_000E;
        bus.out_ready = 1'b0;
        #1;
        chk("bp in_ready low", bus.in_ready, 0);
        flag = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (bus.out_valid !== 1'b1 || bus.result !== 32'h0000_0003 || bus.in_ready !== 1'b0)
                flag = 1'b0;
        end
        chk("bp held stable", flag, 1);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        expect_out("bp second", 32'h0000_001E, 4'b0000, 1'b0);
        issue(OP_ADD, 32'h0000_0005, 32'h0000_0005, 1'b0);
        expect_out("bp third", 32'h0000_000A, 4'b0000, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("bp drained", bus.out_valid, 0);

`ifdef ALU_MUL_EN
        issue(OP_ADD, 32'h0000_0001, 32'h0000_0001, 1'b0);
        issue(OP_MUL, 32'h0001_0000, 32'h0001_0000, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.opcode   = OP_ADD;
        lat  = 0;
        flag = 1'b1;
        while (bus.out_valid !== 1'b1 && lat < 100) begin
            if (bus.in_ready !== 1'b0) flag = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        chk("mul1 latency", lat, 32);
        chk("mul1 busy in_ready", flag, 1);
        expect_out("mul1", 32'h0000_0000, 4'b0110, 1'b0);

        issue(OP_MUL, 32'h0000_0007, 32'h0000_0006, 1'b1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("mul2 latency", lat, 32);
        expect_out("mul2", 32'h0000_002A, 4'b0000, 1'b0);
`else
        issue(OP_MUL, 32'h0000_0007, 32'h0000_0006, 1'b0);
        expect_out("mul disabled", 32'h0000_0000, 4'b0000, 1'b1);
        chk("mul disabled in_ready", bus.in_ready, 1);
`endif

        // Reset pulse while a multiply (or its illegal stand-in) is in flight
        issue(OP_MUL, 32'h0000_0003, 32'h0000_0005, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid reset out_valid", bus.out_valid, 0);
        chk("mid reset result", bus.result, 0);
        @(negedge clk);
        rst_n = 1'b1;
        flag = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.out_valid !== 1'b0) flag = 1'b1;
        end
        chk("no result after abort", flag, 0);
        chk("in_ready after abort", bus.in_ready, 1);

        issue(OP_SUB, 32'h0000_0010, 32'h0000_0001, 1'b0);
        expect_out("sub after abort", 32'h0000_000F, 4'b0010, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
